ej32_fetch: RTL
===============

Name: ej32_fetch

Overview:
- Instruction fetch/prefetch unit for the eJ32 core; the supplying end of the decoder's byte/p_inc interface.
- Fetches 32-bit big-endian words from instruction memory into a byte FIFO.
- Presents one bytecode byte per cycle on data and pops it when the decoder asserts p_inc.
- Handles branch redirects from the BR unit by flushing the FIFO and discarding stale memory responses.

Parameters:
- ASZ, 17, byte address width of program counter and memory bus.
- DEPTH, 8, byte FIFO capacity (power of two, >= 8).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- p_inc  in  1  decoder consumes the current byte.
- br_ld  in  1  redirect request from BR unit.
- br_pc  in  ASZ  redirect target byte address.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  ASZ  word-aligned read address (bits [1:0] always 0).
- mem_ack  in  1  read data valid / request accepted (same cycle).
- mem_rdata  in  32  read word; byte at addr+0 is [31:24].
- data  out  8  current bytecode byte (FIFO head).
- vld  out  1  data holds a real fetched byte.
- pc  out  ASZ  byte address of data.

Behaviour:
- Reset (rst low, async): FIFO empty, count=0, pc=0, fetch address=0, skip=0, state IDLE. Outputs: mem_req=0, mem_addr=0, vld=0, data=8'h00. After release, fetching starts at address 0.
- FIFO empty: vld=0, data=8'h00 (nop); p_inc is ignored and pc holds.
- FIFO non-empty: vld=1, data=head byte. p_inc pops one byte and pc increments by 1, wrapping modulo 2^ASZ.
- Single outstanding request only. mem_addr and mem_req stay stable until mem_ack.
- States:
  - IDLE: issue when free space >= 4 and not br_ld. mem_req=1 from the next cycle; go to REQ.
  - REQ: on mem_ack, write (4 - skip) bytes starting at byte index skip, then clear skip and add 4 to the fetch address (wraps). Go to IDLE. Back-to-back issue is allowed from the following cycle.
  - DROP: a stale request is in flight. mem_req stays 1 (requests cannot be retracted). On mem_ack, discard the data and go to IDLE.
- Redirect (br_ld=1 at edge):
  - Flush FIFO (count=0), pc=br_pc, fetch address=br_pc & ~3, skip=br_pc[1:0].
  - Next state: IDLE if state was IDLE, or if it was REQ/DROP with mem_ack in the same cycle (that response is discarded). DROP if it was REQ/DROP without mem_ack.
- Simultaneous events:
  - br_ld has priority over p_inc and over any FIFO write.
  - p_inc and mem_ack together: count = count + (4 - skip) - 1. The popped byte may be the newly written one only if the FIFO was empty; it is not, because vld=0 means p_inc is ignored.
- Latency: br_ld at edge T with zero-wait mem_ack → mem_req high in cycle T+1 → first byte vld=1 in cycle T+2.
- Steady state: one word per 2 cycles, max. Sustained decode rate is 1 byte/cycle until the FIFO drains.
- Free-space check uses count after the current pop, not before.
- Reset mid-transaction: mem_req drops immediately. The memory side must tolerate an abandoned request.

Test Plan:
- Reset then release; memory word @0 = 32'h10_05_60_AC, zero-wait ack, p_inc=1 each valid cycle → data sequence 10,05,60,AC; pc 0,1,2,3; next mem_addr=4.
- br_ld with br_pc=0x0006, word @4 = 32'hA7_00_03_B1 → first valid byte 03 at pc=6, then B1 at pc=7; bytes A7,00 never appear.
- Memory with 3-cycle ack latency; br_ld to 0x0020 asserted during REQ for address 0x0008 → mem_req held to ack, that word discarded (DROP), next mem_addr=0x0020, no byte from 0x0008 visible.
- p_inc held 0 while fetching → FIFO fills to 8 bytes. No mem_req while free space < 4. One pop still leaves no new request; after 4 pops, request issued.
- p_inc asserted while vld=0 → pc unchanged, data=00. Simultaneous br_ld and p_inc → pc=br_pc, not br_pc+1.
- pc at 2^ASZ-1 with p_inc → pc wraps to 0. Async rst pulse mid-REQ → mem_req=0 immediately; restart fetches from 0.

Source files
------------

// File: rtl/ej32_fetch.sv
// eJ32 instruction prefetch: fetches big-endian 32-bit words into a byte FIFO
// and hands the decoder one bytecode per cycle, with branch redirect/flush.
module ej32_fetch #(
  parameter int ASZ   = 17,
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           p_inc,
  input  logic           br_ld,
  input  logic [ASZ-1:0] br_pc,
  output logic           mem_req,
  output logic [ASZ-1:0] mem_addr,
  input  logic           mem_ack,
  input  logic [31:0]    mem_rdata,
  output logic [7:0]     data,
  output logic           vld,
  output logic [ASZ-1:0] pc
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t         state, state_nxt;
  logic [7:0]     fifo [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [PW-1:0]  wr_idx [4];
  logic [PW:0]    count, count_pop;
  logic [ASZ-1:0] fa;
  logic [1:0]     skip;
  logic [2:0]     nwr;
  logic           pop, wr, issue;

  assign vld       = (count != '0);
  assign data      = vld ? fifo[rd_ptr] : 8'h00;
  assign mem_req   = (state != IDLE);
  assign pop       = p_inc & vld & ~br_ld;
  assign count_pop = count - (PW+1)'(pop);
  assign wr        = (state == REQ) & mem_ack & ~br_ld;
  assign nwr       = 3'd4 - {1'b0, skip};

  // Space is judged after this cycle's pop so a drained slot can be refilled at once
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (!br_ld && (count_pop <= (PW+1)'(DEPTH - 4))) begin
          issue     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ, DROP: begin
        if (mem_ack)    state_nxt = IDLE;
        else if (br_ld) state_nxt = DROP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) wr_idx[i] = wr_ptr + PW'(i) - PW'(skip);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      pc       <= '0;
      fa       <= '0;
      skip     <= '0;
      mem_addr <= '0;
    end else begin
      state <= state_nxt;
      if (issue) mem_addr <= fa;
      if (br_ld) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        pc     <= br_pc;
        fa     <= {br_pc[ASZ-1:2], 2'b00};
        skip   <= br_pc[1:0];
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
          pc     <= pc + ASZ'(1);
        end
        if (wr) begin
          wr_ptr <= wr_ptr + PW'(nwr);
          fa     <= fa + ASZ'(4);
          skip   <= '0;
        end
        count <= count_pop + (wr ? (PW+1)'(nwr) : '0);
      end
    end
  end

  // Byte storage is not reset; vld gates every read of it
  always_ff @(posedge clk) begin
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        if (2'(i) >= skip) fifo[wr_idx[i]] <= mem_rdata[8*(3-i) +: 8];
      end
    end
  end

endmodule
